// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: sequencer states, command opcodes and framebuffer address width.
package hub75_pkg;

   typedef enum logic [2:0] {
      SYNC   = 3'd0,
      CMD    = 3'd1,
      BRIGHT = 3'd2,
      PIXELS = 3'd3,
      CHECK  = 3'd4
   } state_t;

   localparam logic [3:0] OP_FRAME  = 4'h1;
   localparam logic [3:0] OP_BRIGHT = 4'h2;

   function automatic int addr_w_of(input int width, input int height);
      return $clog2(width * height);
   endfunction

   localparam int DEFAULT_ADDR_W = addr_w_of(64, 32);

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Pixel-word input from the SPI slave plus framebuffer/scanner outputs of the sequencer.
interface spi_frame_sequencer_if #(
   parameter int BPP         = 12,
   parameter int ADDR_W      = 11,
   parameter int BRIGHT_BITS = 4
) ();
   logic [BPP-1:0]         pix_data;
   logic                   pix_clk;
   logic [ADDR_W:0]        fb_waddr;
   logic [BPP-1:0]         fb_wdata;
   logic                   fb_we;
   logic                   display_bank;
   logic [BRIGHT_BITS-1:0] brightness;
   logic                   frame_done;
   logic                   checksum_error;
   logic [7:0]             err_count;

   modport master (
      output pix_data, pix_clk,
      input  fb_waddr, fb_wdata, fb_we, display_bank, brightness,
             frame_done, checksum_error, err_count
   );

   modport slave (
      input  pix_data, pix_clk,
      output fb_waddr, fb_wdata, fb_we, display_bank, brightness,
             frame_done, checksum_error, err_count
   );
endinterface

// File: rtl/spi_word_strobe.sv
// pix_clk rising-edge detector; strobe is combinational, word holds the data captured on the last strobe.
module spi_word_strobe #(
   parameter int WIDTH = 12
) (
   input  logic             spi_clk,
   input  logic             reset,
   input  logic             pix_clk,
   input  logic [WIDTH-1:0] pix_data,
   output logic             strobe,
   output logic [WIDTH-1:0] word
);
   logic pix_clk_q;

   assign strobe = pix_clk & ~pix_clk_q;

   always_ff @(posedge spi_clk or posedge reset) begin
      if (reset) begin
         pix_clk_q <= 1'b0;
         word      <= '0;
      end else begin
         pix_clk_q <= pix_clk;
         if (strobe) word <= pix_data;
      end
   end
endmodule

// File: rtl/spi_frame_sequencer.sv
// Sync/command/pixel sequencer feeding the double-buffered HUB75 framebuffer; flips banks per frame.
// Optional trailer checksum check enabled by `FRAME_CHECKSUM_EN.
module spi_frame_sequencer
   import hub75_pkg::*;
#(
   parameter int                       BITS_PER_PIXEL = 12,
   parameter int                       PANEL_WIDTH    = 64,
   parameter int                       PANEL_HEIGHT   = 32,
   parameter logic [BITS_PER_PIXEL-1:0] SYNC_WORD     = 12'hFFF,
   parameter int                       BRIGHT_BITS    = 4
) (
   input  logic                   spi_clk,
   input  logic                   reset,
   spi_frame_sequencer_if.slave   bus
);
   localparam int                ADDR_W   = addr_w_of(PANEL_WIDTH, PANEL_HEIGHT);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PANEL_WIDTH * PANEL_HEIGHT - 1);

   logic                      strobe;
   logic [BITS_PER_PIXEL-1:0] word_q;
   logic [BITS_PER_PIXEL-1:0] word;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      index_q;
   logic [ADDR_W:0]        fb_waddr_q;
   logic                   fb_we_q, frame_done_q, bank_q;
   logic [BRIGHT_BITS-1:0] brightness_q;
   logic                   is_last, pix_wr, flip, idx_clr, bright_ld;

   // The captured word doubles as fb_wdata: it is valid exactly in the fb_we cycle.
   spi_word_strobe #(.WIDTH(BITS_PER_PIXEL)) u_word_strobe (
      .spi_clk  (spi_clk),
      .reset    (reset),
      .pix_clk  (bus.pix_clk),
      .pix_data (bus.pix_data),
      .strobe   (strobe),
      .word     (word_q)
   );

   assign word    = bus.pix_data;
   assign is_last = (index_q == LAST_IDX);

`ifdef FRAME_CHECKSUM_EN
   logic [BITS_PER_PIXEL-1:0] sum_q;
   logic                      cs_bad, cs_err_q;
   logic [7:0]                err_count_q;
`endif

   always_ff @(posedge spi_clk or posedge reset) begin
      if (reset) state_q <= SYNC;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (strobe) begin
         case (state_q)
            SYNC:    if (word == SYNC_WORD) state_d = CMD;
            CMD: begin
               if (word[3:0] == OP_FRAME)       state_d = PIXELS;
               else if (word[3:0] == OP_BRIGHT) state_d = BRIGHT;
               else                             state_d = SYNC;
            end
            BRIGHT:  state_d = SYNC;
`ifdef FRAME_CHECKSUM_EN
            PIXELS:  if (is_last) state_d = CHECK;
`else
            PIXELS:  if (is_last) state_d = SYNC;
`endif
            default: state_d = SYNC;
         endcase
      end
   end

   always_comb begin
      pix_wr    = strobe && (state_q == PIXELS);
      idx_clr   = strobe && (state_q == CMD) && (word[3:0] == OP_FRAME);
      bright_ld = strobe && (state_q == BRIGHT);
`ifdef FRAME_CHECKSUM_EN
      flip      = strobe && (state_q == CHECK) && (word == sum_q);
      cs_bad    = strobe && (state_q == CHECK) && (word != sum_q);
`else
      flip      = pix_wr && is_last;
`endif
   end

   always_ff @(posedge spi_clk or posedge reset) begin
      if (reset) begin
         index_q      <= '0;
         fb_waddr_q   <= '0;
         fb_we_q      <= 1'b0;
         frame_done_q <= 1'b0;
         bank_q       <= 1'b0;
         brightness_q <= '1;
      end else begin
         fb_we_q      <= pix_wr;
         frame_done_q <= flip;
         // Address uses the pre-flip bank, so the final write lands in the old write bank.
         if (pix_wr) fb_waddr_q <= {~bank_q, index_q};
         if (flip)   bank_q     <= ~bank_q;
         if (idx_clr)                index_q <= '0;
         else if (pix_wr && !is_last) index_q <= index_q + 1'b1;
         if (bright_ld) brightness_q <= word[BRIGHT_BITS-1:0];
      end
   end

`ifdef FRAME_CHECKSUM_EN
   always_ff @(posedge spi_clk or posedge reset) begin
      if (reset) begin
         sum_q       <= '0;
         cs_err_q    <= 1'b0;
         err_count_q <= '0;
      end else begin
         cs_err_q <= cs_bad;
         if (idx_clr)     sum_q <= '0;
         else if (pix_wr) sum_q <= sum_q + word;
         if (cs_bad && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
   end

   assign bus.checksum_error = cs_err_q;
   assign bus.err_count      = err_count_q;
`else
   assign bus.checksum_error = 1'b0;
   assign bus.err_count      = 8'd0;
`endif

   assign bus.fb_waddr     = fb_waddr_q;
   assign bus.fb_wdata     = word_q;
   assign bus.fb_we        = fb_we_q;
   assign bus.display_bank = bank_q;
   assign bus.brightness   = brightness_q;
   assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected writes/flips/checksum errors, a monitor pops on each output event.
module tb_spi_frame_sequencer;
   logic spi_clk = 1'b0;
   logic reset;

   always #5 spi_clk = ~spi_clk;

   spi_frame_sequencer_if #(.BPP(12), .ADDR_W(11), .BRIGHT_BITS(4)) bus ();

   spi_frame_sequencer dut (
      .spi_clk (spi_clk),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct {
      int         kind;   // 0 write, 1 flip, 2 checksum error
      logic [11:0] addr;
      logic [11:0] data;
   } ev_t;

   ev_t  exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic exp_bank = 1'b0;
   int   exp_errs = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [11:0] addr, input logic [11:0] data);
      ev_t ev;
      ev.kind = kind;
      ev.addr = addr;
      ev.data = data;
      exp_q.push_back(ev);
   endtask

   // Monitor
   initial begin
      ev_t ev;
      forever begin
         @(negedge spi_clk);
         if (reset === 1'b0) begin
            if (bus.fb_we) begin
               if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                           bus.fb_waddr, bus.fb_wdata);
               end else begin
                  ev = exp_q.pop_front();
                  check("wr_addr", 32'(bus.fb_waddr), 32'(ev.addr));
                  check("wr_data", 32'(bus.fb_wdata), 32'(ev.data));
               end
            end
            if (bus.frame_done) begin
               if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                  checks++; failures++;
                  $display("FAIL unexpected_flip: got bank %0h expected no frame_done", bus.display_bank);
               end else begin
                  ev = exp_q.pop_front();
                  check("flip_bank", 32'(bus.display_bank), 32'(ev.data));
               end
            end
            if (bus.checksum_error) begin
               if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
                  checks++; failures++;
                  $display("FAIL unexpected_cserr: got err_count %0d expected no checksum_error", bus.err_count);
               end else begin
                  ev = exp_q.pop_front();
                  check("cserr_count", 32'(bus.err_count), 32'(ev.data));
               end
            end
         end
      end
   end

   task automatic send_word(input logic [11:0] w);
      @(negedge spi_clk);
      bus.pix_data = w;
      bus.pix_clk  = 1'b1;
      @(negedge spi_clk);
      bus.pix_clk  = 1'b0;
      @(negedge spi_clk);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge spi_clk);
      repeat (3) @(negedge spi_clk);
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Full frame: pixel i = (i & mask) ^ pat, FFF forced at index fff_at; bad corrupts the trailer.
   task automatic run_frame(input logic [11:0] mask, input logic [11:0] pat, input int fff_at, input bit bad);
      logic [11:0] d;
      logic [11:0] sum;
      logic        wb;
      sum = '0;
      wb  = ~exp_bank;
      send_word(12'hFFF);
      send_word(12'h001);
      for (int i = 0; i < 2048; i++) begin
         d = (12'(i) & mask) ^ pat;
         if (i == fff_at) d = 12'hFFF;
         push(0, {wb, 11'(i)}, d);
         sum = sum + d;
`ifndef FRAME_CHECKSUM_EN
         if (i == 2047) begin
            exp_bank = ~exp_bank;
            push(1, 12'd0, 12'(exp_bank));
         end
`endif
         send_word(d);
      end
`ifdef FRAME_CHECKSUM_EN
      if (!bad) begin
         exp_bank = ~exp_bank;
         push(1, 12'd0, 12'(exp_bank));
      end else begin
         exp_errs++;
         push(2, 12'd0, 12'(exp_errs));
      end
      send_word(sum + 12'(bad));
`else
      if (bad) $display("note: trailer ignored without checksum");
`endif
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_fb_we"},        32'(bus.fb_we), 32'd0);
      check({tag, "_fb_waddr"},     32'(bus.fb_waddr), 32'd0);
      check({tag, "_fb_wdata"},     32'(bus.fb_wdata), 32'd0);
      check({tag, "_display_bank"}, 32'(bus.display_bank), 32'd0);
      check({tag, "_brightness"},   32'(bus.brightness), 32'hF);
      check({tag, "_frame_done"},   32'(bus.frame_done), 32'd0);
      check({tag, "_cserr"},        32'(bus.checksum_error), 32'd0);
      check({tag, "_err_count"},    32'(bus.err_count), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.pix_clk  = 1'b0;
      bus.pix_data = '0;
      repeat (3) @(negedge spi_clk);
      check_reset_state("rst");
      reset = 1'b0;

      // Frame 000..7FF into bank 1, then flip to display bank 1
      run_frame(12'hFFF, 12'h000, -1, 1'b0);
      drain("t1_drain");
      check("t1_bank", 32'(bus.display_bank), 32'd1);

      // Brightness command after a garbage word
      send_word(12'h123);
      send_word(12'hFFF);
      send_word(12'h002);
      send_word(12'h005);
      drain("t2_drain");
      check("t2_brightness", 32'(bus.brightness), 32'h5);

      // Unknown opcode returns to SYNC; next frame has FFF as pixel data at index 500
      send_word(12'hFFF);
      send_word(12'h00F);
      run_frame(12'hFFF, 12'h5A5, 500, 1'b0);
      drain("t3_drain");
      check("t3_bank", 32'(bus.display_bank), 32'd0);

      // Reset after 100 pixels, then a full frame from index 0
      send_word(12'hFFF);
      send_word(12'h001);
      for (int i = 0; i < 100; i++) begin
         push(0, {1'b1, 11'(i)}, 12'(i) ^ 12'h3C3);
         send_word(12'(i) ^ 12'h3C3);
      end
      drain("t4_partial_drain");
      reset = 1'b1;
      @(negedge spi_clk);
      check_reset_state("midrst");
      reset    = 1'b0;
      exp_bank = 1'b0;
      exp_errs = 0;
      run_frame(12'hFFF, 12'hA00, -1, 1'b0);
      drain("t4_drain");
      check("t4_bank", 32'(bus.display_bank), 32'd1);

`ifdef FRAME_CHECKSUM_EN
      // All-001 frame sums to 800: good trailer flips, 801 raises an error
      run_frame(12'h000, 12'h001, -1, 1'b0);
      drain("t5_good_drain");
      check("t5_good_bank", 32'(bus.display_bank), 32'd0);
      run_frame(12'h000, 12'h001, -1, 1'b1);
      drain("t5_bad_drain");
      check("t5_bad_bank", 32'(bus.display_bank), 32'd0);
      check("t5_err_count", 32'(bus.err_count), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
